// File: rtl/sample_player.sv
// sample_player: sample-rate strobe, address-window walker and BRAM latency absorber for audio playback.
// Optional SAMPLE_PLAYER_GAIN_EN adds a 4-bit saturating gain stage (gain=4 is unity).
module sample_player #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int DIV    = 12500,
  parameter int RD_LAT = 1
) (
  input  logic              CLK100MHZ,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic              loop,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] end_addr,
  output logic              bram_en,
  output logic [ADDR_W-1:0] bram_addr,
  input  logic [DATA_W-1:0] bram_dout,
`ifdef SAMPLE_PLAYER_GAIN_EN
  input  logic [3:0]        gain,
`endif
  output logic              tick,
  output logic [DATA_W-1:0] sample,
  output logic              sample_valid,
  output logic              busy,
  output logic              done
);
  localparam int DIV_W = $clog2(DIV);
  typedef enum logic [1:0] {IDLE, PLAY, DRAIN} state_t;
  state_t            r_state, w_next;
  logic [DIV_W-1:0]  r_div;
  logic [ADDR_W-1:0] r_addr, r_start, r_end, r_last;
  logic              r_loop, r_valid, r_done;
  logic [RD_LAT-1:0] r_pipe;
  logic [DATA_W-1:0] r_sample;
  logic              w_wrap, w_tick, w_accept, w_at_end, w_empty, w_exit;
  assign w_wrap   = r_div == DIV_W'(DIV - 1);
  assign w_tick   = r_state == PLAY && w_wrap;
  assign w_accept = r_state == IDLE && start && !stop;
  assign w_at_end = r_addr == r_end;
  assign w_exit   = r_pipe[RD_LAT-1];
  always_comb begin
    w_next = r_state;
    w_next = w_accept ? PLAY :
             (r_state == PLAY && (stop || (w_tick && w_at_end && !r_loop))) ? DRAIN :
             (r_state == DRAIN && w_empty) ? IDLE : r_state;
  end
  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_div   <= '0;
      r_addr  <= '0;
      r_start <= '0;
      r_end   <= '0;
      r_last  <= '0;
      r_loop  <= 1'b0;
      r_pipe  <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      // Loading DIV-1 on start makes the first tick land in the first PLAY cycle.
      r_div   <= w_accept ? DIV_W'(DIV - 1) : (w_next != PLAY || w_wrap) ? '0 : r_div + 1'b1;
      r_pipe  <= RD_LAT'({r_pipe, w_tick});
      r_done  <= r_state == DRAIN && w_empty;
      if (w_accept) begin
        r_start <= start_addr;
        r_end   <= end_addr;
        r_loop  <= loop;
        r_addr  <= start_addr;
      end else if (w_tick) begin
        r_addr <= (w_at_end && r_loop) ? r_start : r_addr + 1'b1;
        r_last <= r_addr;
      end
    end
  end
`ifdef SAMPLE_PLAYER_GAIN_EN
  logic [DATA_W+1:0] w_scaled;
  logic [DATA_W-1:0] r_gs;
  logic              r_gv;
  assign w_scaled = (DATA_W+2)'(((DATA_W+4)'(bram_dout) * (DATA_W+4)'(gain)) >> 2);
  assign w_empty  = r_pipe == '0 && !r_gv;
  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      r_gs     <= '0;
      r_gv     <= 1'b0;
      r_sample <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_gv    <= w_exit;
      r_valid <= r_gv;
      if (w_exit) r_gs <= |w_scaled[DATA_W+1:DATA_W] ? '1 : w_scaled[DATA_W-1:0];
      if (r_gv) r_sample <= r_gs;
    end
  end
`else
  assign w_empty = r_pipe == '0;
  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      r_sample <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_valid <= w_exit;
      if (w_exit) r_sample <= bram_dout;
    end
  end
`endif
  assign tick         = w_tick;
  assign bram_en      = w_tick;
  assign bram_addr    = w_tick ? r_addr : r_last;
  assign sample       = r_sample;
  assign sample_valid = r_valid;
  assign busy         = r_state != IDLE;
  assign done         = r_done;
endmodule

// File: tb/tb_sample_player.sv
// tb_sample_player: directed checks of playback timing, addressing, looping, stop, reset and gain.
module tb_sample_player;
`ifdef SAMPLE_PLAYER_GAIN_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif
  logic       clk = 1'b0, reset = 1'b1, start = 1'b0, stop = 1'b0, loop = 1'b0;
  logic [7:0] start_addr = '0, end_addr = '0, bram_addr, bram_dout = '0, sample;
  logic       bram_en, tick, sample_valid, busy, done;
  logic [3:0] gain = 4'd4;
  int total = 0, bad = 0, cyc = 0, en_cnt = 0;
  int tick_a[$], tick_c[$], sv_d[$], sv_c[$], done_c[$];
  sample_player #(.DATA_W(8), .ADDR_W(8), .DIV(4), .RD_LAT(1)) dut (
    .CLK100MHZ(clk), .reset(reset), .start(start), .stop(stop), .loop(loop),
    .start_addr(start_addr), .end_addr(end_addr), .bram_en(bram_en), .bram_addr(bram_addr),
    .bram_dout(bram_dout),
`ifdef SAMPLE_PLAYER_GAIN_EN
    .gain(gain),
`endif
    .tick(tick), .sample(sample), .sample_valid(sample_valid), .busy(busy), .done(done));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (bram_en) bram_dout <= bram_addr + 8'd10;
  always @(negedge clk) if (!reset) begin
    if (tick) begin tick_a.push_back(int'(bram_addr)); tick_c.push_back(cyc); end
    if (bram_en) en_cnt++;
    if (sample_valid) begin sv_d.push_back(int'(sample)); sv_c.push_back(cyc); end
    if (done) done_c.push_back(cyc);
  end
  task automatic clear_log();
    tick_a.delete(); tick_c.delete(); sv_d.delete(); sv_c.delete(); done_c.delete(); en_cnt = 0;
  endtask
  task automatic pulse_start(input int a, input int b, input logic lp, output int s);
    @(posedge clk); #1;
    start_addr = 8'(a); end_addr = 8'(b); loop = lp; start = 1'b1; s = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask
  task automatic wait_done();
    for (int i = 0; i < 400 && done_c.size() == 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
  endtask
  task automatic test_reset();
    total++; if ({bram_en, tick, sample_valid, busy, done} !== 5'b0) begin bad++; $display("FAIL reset_ctl got=%b want=00000", {bram_en, tick, sample_valid, busy, done}); end
    total++; if (bram_addr !== 8'd0) begin bad++; $display("FAIL reset_addr got=%0d want=0", bram_addr); end
    total++; if (sample !== 8'd0) begin bad++; $display("FAIL reset_sample got=%0d want=0", sample); end
  endtask
  task automatic test_oneshot();
    int s;
    clear_log(); pulse_start(2, 5, 1'b0, s); wait_done();
    total++; if (tick_a.size() !== 4) begin bad++; $display("FAIL os_ticks got=%0d want=4", tick_a.size()); end
    total++; if (en_cnt !== 4) begin bad++; $display("FAIL os_en got=%0d want=4", en_cnt); end
    for (int i = 0; i < 4; i++) begin
      total++; if (tick_a[i] !== 2 + i) begin bad++; $display("FAIL os_addr%0d got=%0d want=%0d", i, tick_a[i], 2 + i); end
      total++; if (tick_c[i] !== s + 1 + 4 * i) begin bad++; $display("FAIL os_tickcyc%0d got=%0d want=%0d", i, tick_c[i], s + 1 + 4 * i); end
      total++; if (sv_d[i] !== 12 + i) begin bad++; $display("FAIL os_sample%0d got=%0d want=%0d", i, sv_d[i], 12 + i); end
      total++; if (sv_c[i] !== s + 1 + 4 * i + LAT) begin bad++; $display("FAIL os_svcyc%0d got=%0d want=%0d", i, sv_c[i], s + 1 + 4 * i + LAT); end
    end
    total++; if (done_c.size() !== 1) begin bad++; $display("FAIL os_done_cnt got=%0d want=1", done_c.size()); end
    total++; if (done_c[0] !== s + 13 + LAT + 1) begin bad++; $display("FAIL os_done_cyc got=%0d want=%0d", done_c[0], s + 13 + LAT + 1); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL os_busy got=%b want=0", busy); end
  endtask
  task automatic test_loop_stop();
    int s;
    int exp_a[7] = '{2, 3, 4, 5, 2, 3, 4};
    clear_log(); pulse_start(2, 5, 1'b1, s);
    while (cyc != s + 26) begin @(posedge clk); #1; end
    stop = 1'b1; @(posedge clk); #1; stop = 1'b0;
    wait_done();
    total++; if (tick_a.size() !== 7) begin bad++; $display("FAIL lp_ticks got=%0d want=7", tick_a.size()); end
    total++; if (sv_d.size() !== 7) begin bad++; $display("FAIL lp_samples got=%0d want=7", sv_d.size()); end
    for (int i = 0; i < 7; i++) begin
      total++; if (tick_a[i] !== exp_a[i]) begin bad++; $display("FAIL lp_addr%0d got=%0d want=%0d", i, tick_a[i], exp_a[i]); end
      total++; if (sv_d[i] !== exp_a[i] + 10) begin bad++; $display("FAIL lp_sample%0d got=%0d want=%0d", i, sv_d[i], exp_a[i] + 10); end
    end
    total++; if (done_c.size() !== 1) begin bad++; $display("FAIL lp_done_cnt got=%0d want=1", done_c.size()); end
    total++; if (done_c[0] !== s + 25 + LAT + 1) begin bad++; $display("FAIL lp_done_cyc got=%0d want=%0d", done_c[0], s + 25 + LAT + 1); end
  endtask
  task automatic test_wrap();
    int s;
    int exp_a[4] = '{254, 255, 0, 1};
    clear_log(); pulse_start(254, 1, 1'b0, s); wait_done();
    total++; if (tick_a.size() !== 4) begin bad++; $display("FAIL wr_ticks got=%0d want=4", tick_a.size()); end
    for (int i = 0; i < 4; i++) begin
      total++; if (tick_a[i] !== exp_a[i]) begin bad++; $display("FAIL wr_addr%0d got=%0d want=%0d", i, tick_a[i], exp_a[i]); end
      total++; if (sv_d[i] !== (exp_a[i] + 10) % 256) begin bad++; $display("FAIL wr_sample%0d got=%0d want=%0d", i, sv_d[i], (exp_a[i] + 10) % 256); end
    end
    total++; if (done_c.size() !== 1) begin bad++; $display("FAIL wr_done_cnt got=%0d want=1", done_c.size()); end
  endtask
  task automatic test_single_busy_start();
    int s, d;
    clear_log(); pulse_start(7, 7, 1'b0, s); pulse_start(20, 21, 1'b0, d);
    wait_done(); repeat (20) @(negedge clk);
    total++; if (tick_a.size() !== 1) begin bad++; $display("FAIL sg_ticks got=%0d want=1", tick_a.size()); end
    total++; if (tick_a[0] !== 7) begin bad++; $display("FAIL sg_addr got=%0d want=7", tick_a[0]); end
    total++; if (sv_d.size() !== 1 || sv_d[0] !== 17) begin bad++; $display("FAIL sg_sample got=%0d (n=%0d) want=17", sv_d[0], sv_d.size()); end
    total++; if (done_c.size() !== 1) begin bad++; $display("FAIL sg_done_cnt got=%0d want=1", done_c.size()); end
  endtask
  task automatic test_start_stop_idle();
    clear_log();
    @(posedge clk); #1; start_addr = 8'd2; end_addr = 8'd5; start = 1'b1; stop = 1'b1;
    @(posedge clk); #1; start = 1'b0; stop = 1'b0;
    repeat (12) @(negedge clk);
    total++; if (tick_a.size() !== 0) begin bad++; $display("FAIL ss_ticks got=%0d want=0", tick_a.size()); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL ss_busy got=%b want=0", busy); end
  endtask
  task automatic test_reset_midflight();
    int s;
    clear_log(); pulse_start(2, 5, 1'b0, s);
    while (cyc != s + 2) begin @(posedge clk); #1; end
    reset = 1'b1; #1;
    total++; if (sample !== 8'd0) begin bad++; $display("FAIL rm_sample got=%0d want=0", sample); end
    total++; if ({busy, done, sample_valid, bram_en} !== 4'b0) begin bad++; $display("FAIL rm_ctl got=%b want=0000", {busy, done, sample_valid, bram_en}); end
    repeat (3) @(posedge clk); #1; reset = 1'b0;
    repeat (10) @(negedge clk);
    total++; if (sv_d.size() !== 0 || done_c.size() !== 0) begin bad++; $display("FAIL rm_quiet got=%0d/%0d want=0/0", sv_d.size(), done_c.size()); end
    clear_log(); pulse_start(2, 5, 1'b0, s); wait_done();
    total++; if (tick_a[0] !== 2) begin bad++; $display("FAIL rm_replay_addr got=%0d want=2", tick_a[0]); end
    total++; if (sv_d.size() !== 4 || sv_d[0] !== 12) begin bad++; $display("FAIL rm_replay got=%0d (n=%0d) want=12", sv_d[0], sv_d.size()); end
  endtask
`ifdef SAMPLE_PLAYER_GAIN_EN
  task automatic test_gain();
    int s;
    gain = 4'd8;
    clear_log(); pulse_start(90, 90, 1'b0, s); wait_done();
    total++; if (sv_d[0] !== 200) begin bad++; $display("FAIL gn_200 got=%0d want=200", sv_d[0]); end
    total++; if (sv_c[0] !== s + 4) begin bad++; $display("FAIL gn_lat got=%0d want=%0d", sv_c[0], s + 4); end
    clear_log(); pulse_start(190, 190, 1'b0, s); wait_done();
    total++; if (sv_d[0] !== 255) begin bad++; $display("FAIL gn_sat got=%0d want=255", sv_d[0]); end
    gain = 4'd0;
    clear_log(); pulse_start(90, 90, 1'b0, s); wait_done();
    total++; if (sv_d.size() !== 1 || sv_d[0] !== 0) begin bad++; $display("FAIL gn_zero got=%0d want=0", sv_d[0]); end
    gain = 4'd4;
  endtask
`endif
  initial begin
    repeat (3) @(posedge clk); #1;
    test_reset();
    reset = 1'b0;
    test_oneshot();
    test_loop_stop();
    test_wrap();
    test_single_busy_start();
    test_start_stop_idle();
    test_reset_midflight();
`ifdef SAMPLE_PLAYER_GAIN_EN
    test_gain();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
